wb_sram_ctrl: RTL and testbench

//  Wishbone classic slave on the Caravel user-project bus that bridges 32-bit

---
 rtl/wb_sram_ctrl_if.sv | 21 ++
 rtl/wb_sram_ctrl.sv | 143 ++++++++++++++
 tb/tb_wb_sram_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_ctrl_if.sv
// Wishbone classic slave-side bus bundle between the management SoC and wb_sram_ctrl.
interface wb_sram_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave bridging 32-bit accesses to a single-port synchronous SRAM.
// Optional access counters are built only when WB_SRAM_STATS_EN is defined.
module wb_sram_ctrl #(
  parameter int          ADDR_WIDTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          SRAM_LATENCY = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_sram_ctrl_if.slave         wbs,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [3:0]            sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_din,
  input  logic [31:0]           sram_dout,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RD_WAIT, ACK} state_t;

  localparam logic [1:0] WAIT_INIT = 2'(SRAM_LATENCY - 1);

  state_t                  state_q, state_d;
  logic [1:0]              wait_q;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_q, dat_d;
  logic                    csb_d, web_d;
  logic [3:0]              wmask_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [31:0]             din_d;
  logic                    req, hit;
  logic                    unused_ok;

  // The cycle in which ack is high is already IDLE; the still-asserted strobe must not restart.
  assign req       = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
  assign hit       = (wbs.wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign unused_ok = ^wbs.wbs_adr_i[1:0];

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == READ)
        wait_q <= WAIT_INIT;
      else if (state_q == RD_WAIT && wait_q != 2'd0)
        wait_q <= wait_q - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = hit ? (wbs.wbs_we_i ? WRITE : READ) : ACK;
      WRITE:   state_d = wbs.wbs_cyc_i ? ACK : IDLE;
      READ:    state_d = wbs.wbs_cyc_i ? RD_WAIT : IDLE;
      RD_WAIT: begin
        if (!wbs.wbs_cyc_i)       state_d = IDLE;
        else if (wait_q == 2'd0)  state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = 4'h0;
    addr_d  = sram_addr;
    din_d   = sram_din;
    dat_d   = dat_q;
    ack_d   = (state_q == ACK);
    if (state_q == IDLE && req) begin
      addr_d = wbs.wbs_adr_i[ADDR_WIDTH+1:2];
      din_d  = wbs.wbs_dat_i;
      if (hit) begin
        csb_d = 1'b0;
        if (wbs.wbs_we_i) begin
          web_d   = 1'b0;
          wmask_d = wbs.wbs_sel_i;
        end
      end else if (!wbs.wbs_we_i) begin
        dat_d = 32'h0;
      end
    end
    if (state_q == RD_WAIT && wbs.wbs_cyc_i && wait_q == 2'd0)
      dat_d = sram_dout;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_wmask <= 4'h0;
      sram_addr  <= '0;
      sram_din   <= 32'h0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      sram_csb   <= csb_d;
      sram_web   <= web_d;
      sram_wmask <= wmask_d;
      sram_addr  <= addr_d;
      sram_din   <= din_d;
    end
  end

`ifdef WB_SRAM_STATS_EN
  logic hit_q, we_q;

  // Only hit accesses that reach ACK are counted; misses and aborted cycles never do.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hit_q    <= 1'b0;
      we_q     <= 1'b0;
      rd_count <= 16'h0;
      wr_count <= 16'h0;
    end else begin
      if (state_q == IDLE && req) begin
        hit_q <= hit;
        we_q  <= wbs.wbs_we_i;
      end
      if (state_q == ACK && hit_q) begin
        if (we_q) wr_count <= wr_count + 16'd1;
        else      rd_count <= rd_count + 16'd1;
      end
    end
  end
`else
  assign rd_count = 16'h0;
  assign wr_count = 16'h0;
`endif

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Directed bench: one controller with SRAM_LATENCY=1 and one with SRAM_LATENCY=3, each on a model SRAM.
module tb_wb_sram_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;
  wb_sram_ctrl_if b1();
  wb_sram_ctrl_if b3();

  logic        csb1, web1, csb3, web3;
  logic [3:0]  wm1, wm3;
  logic [7:0]  a1, a3;
  logic [31:0] din1, din3;
  logic [31:0] dout1 = 32'h0, dout3 = 32'h0, p0 = 32'h0, p1 = 32'h0;
  logic [15:0] rc1, wc1, rc3, wc3;
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];

  int checks = 0;
  int errors = 0;

`ifdef WB_SRAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  wb_sram_ctrl #(.ADDR_WIDTH(8), .BASE_ADDR(32'h3000_0000), .SRAM_LATENCY(1)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst1), .wbs(b1),
    .sram_csb(csb1), .sram_web(web1), .sram_wmask(wm1), .sram_addr(a1),
    .sram_din(din1), .sram_dout(dout1), .rd_count(rc1), .wr_count(wc1)
  );

  wb_sram_ctrl #(.ADDR_WIDTH(8), .BASE_ADDR(32'h3000_0000), .SRAM_LATENCY(3)) u3 (
    .wb_clk_i(clk), .wb_rst_i(rst3), .wbs(b3),
    .sram_csb(csb3), .sram_web(web3), .sram_wmask(wm3), .sram_addr(a3),
    .sram_din(din3), .sram_dout(dout3), .rd_count(rc3), .wr_count(wc3)
  );

  function automatic logic [31:0] bytemask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  always @(posedge clk) begin
    if (!csb1) begin
      if (!web1) mem1[a1] <= (mem1[a1] & ~bytemask(wm1)) | (din1 & bytemask(wm1));
      else       dout1 <= mem1[a1];
    end
  end

  always @(posedge clk) begin
    if (!csb3) begin
      if (!web3) mem3[a3] <= (mem3[a3] & ~bytemask(wm3)) | (din3 & bytemask(wm3));
      else       p0 <= mem3[a3];
    end
    p1    <= p0;
    dout3 <= p1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s3, input bit cyc, input bit we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (s3) begin
      b3.wbs_cyc_i = cyc; b3.wbs_stb_i = cyc; b3.wbs_we_i = we;
      b3.wbs_sel_i = sel; b3.wbs_adr_i = adr; b3.wbs_dat_i = dat;
    end else begin
      b1.wbs_cyc_i = cyc; b1.wbs_stb_i = cyc; b1.wbs_we_i = we;
      b1.wbs_sel_i = sel; b1.wbs_adr_i = adr; b1.wbs_dat_i = dat;
    end
  endtask

  // Edge index n counts from the request-sampling edge (n=0).
  task automatic xfer(input bit s3, input bit we, input logic [3:0] sel, input logic [31:0] adr,
                      input logic [31:0] dat, output int ack_edge, output logic [31:0] rdata,
                      output int csb_low, output int web_low, output logic [7:0] acc_addr);
    ack_edge = -1; rdata = 32'hx; csb_low = 0; web_low = 0; acc_addr = 8'hx;
    @(posedge clk); #1;
    drive(s3, 1'b1, we, sel, adr, dat);
    for (int n = 0; n <= 20; n++) begin
      @(posedge clk); #1;
      if (!(s3 ? csb3 : csb1)) begin
        csb_low++;
        acc_addr = s3 ? a3 : a1;
        if (!(s3 ? web3 : web1)) web_low++;
      end
      if (s3 ? b3.wbs_ack_o : b1.wbs_ack_o) begin
        ack_edge = n;
        rdata = s3 ? b3.wbs_dat_o : b1.wbs_dat_o;
        break;
      end
    end
    drive(s3, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  int          ae, cl, wl, ack_seen;
  logic [31:0] rd;
  logic [7:0]  aa;

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) begin mem1[i] = 32'h0; mem3[i] = 32'h0; end
    mem3[2] = 32'hCAFE_F00D;
    mem3[3] = 32'h1122_3344;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'h0, b1.wbs_ack_o}, 32'h0);
    chk("rst_dat", b1.wbs_dat_o, 32'h0);
    chk("rst_csb", {31'h0, csb1}, 32'h1);
    chk("rst_web", {31'h0, web1}, 32'h1);
    chk("rst_wmask", {28'h0, wm1}, 32'h0);
    chk("rst_addr", {24'h0, a1}, 32'h0);
    chk("rst_din", din1, 32'h0);
    chk("rst_counts", {rc1, wc1}, 32'h0);
    rst1 = 1'b0; rst3 = 1'b0;

    xfer(1'b0, 1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, ae, rd, cl, wl, aa);
    chk("w1_ack_edge", ae, 2);
    chk("w1_web_cycles", wl, 1);
    chk("w1_sram_addr", {24'h0, aa}, 32'h4);
    chk("w1_mem", mem1[4], 32'hDEAD_BEEF);
    xfer(1'b0, 1'b0, 4'hF, 32'h3000_0010, 32'h0, ae, rd, cl, wl, aa);
    chk("r1_ack_edge", ae, 3);
    chk("r1_data", rd, 32'hDEAD_BEEF);

    xfer(1'b0, 1'b1, 4'h1, 32'h3000_0010, 32'h0000_00AA, ae, rd, cl, wl, aa);
    chk("w2_ack_edge", ae, 2);
    xfer(1'b0, 1'b0, 4'hF, 32'h3000_0010, 32'h0, ae, rd, cl, wl, aa);
    chk("r2_data", rd, 32'hDEAD_BEAA);

    xfer(1'b0, 1'b0, 4'hF, 32'h3000_0400, 32'h0, ae, rd, cl, wl, aa);
    chk("miss_ack_edge", ae, 1);
    chk("miss_data", rd, 32'h0);
    chk("miss_csb_cycles", cl, 0);

    xfer(1'b0, 1'b1, 4'h0, 32'h3000_0010, 32'h1234_5678, ae, rd, cl, wl, aa);
    chk("sel0_ack_edge", ae, 2);
    chk("sel0_csb_cycles", cl, 1);
    xfer(1'b0, 1'b0, 4'hF, 32'h3000_0010, 32'h0, ae, rd, cl, wl, aa);
    chk("sel0_readback", rd, 32'hDEAD_BEAA);

    chk("u1_wr_count", {16'h0, wc1}, STATS ? 32'd3 : 32'd0);
    chk("u1_rd_count", {16'h0, rc1}, STATS ? 32'd3 : 32'd0);

    // Reset between the sampling edge and the SRAM capture edge of a write.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 4'hF, 32'h3000_0010, 32'h5555_5555);
    @(posedge clk); #1;
    chk("rstw_csb_pre", {31'h0, csb1}, 32'h0);
    rst1 = 1'b1;
    #1;
    chk("rstw_csb", {31'h0, csb1}, 32'h1);
    chk("rstw_ack", {31'h0, b1.wbs_ack_o}, 32'h0);
    chk("rstw_web_wmask", {27'h0, web1, wm1}, 32'h10);
    chk("rstw_addr_din", {a1, din1[23:0]}, 32'h0);
    chk("rstw_dat", b1.wbs_dat_o, 32'h0);
    chk("rstw_counts", {rc1, wc1}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst1 = 1'b0;
    xfer(1'b0, 1'b0, 4'hF, 32'h3000_0010, 32'h0, ae, rd, cl, wl, aa);
    chk("rstw_readback", rd, 32'hDEAD_BEAA);

    xfer(1'b1, 1'b0, 4'hF, 32'h3000_0008, 32'h0, ae, rd, cl, wl, aa);
    chk("l3_ack_edge", ae, 5);
    chk("l3_data", rd, 32'hCAFE_F00D);

    // Abandon a read while the latency-3 controller is waiting on the SRAM.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_000C, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    ack_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b3.wbs_ack_o) ack_seen = 1;
    end
    chk("abort_no_ack", ack_seen, 0);
    chk("abort_dat_held", b3.wbs_dat_o, 32'hCAFE_F00D);
    xfer(1'b1, 1'b0, 4'hF, 32'h3000_000C, 32'h0, ae, rd, cl, wl, aa);
    chk("abort_next_ack_edge", ae, 5);
    chk("abort_next_data", rd, 32'h1122_3344);
    chk("u3_rd_count", {16'h0, rc3}, STATS ? 32'd2 : 32'd0);
    chk("u3_wr_count", {16'h0, wc3}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
